// File: rtl/ex_commit_stage_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ex_commit_stage_pkg: branch one-hot indices and EX/MEM entry layout      |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
package ex_commit_stage_pkg;

  localparam int BJ_BEQ  = 0;
  localparam int BJ_BNE  = 1;
  localparam int BJ_BLT  = 2;
  localparam int BJ_BGE  = 3;
  localparam int BJ_BLTU = 4;
  localparam int BJ_BGEU = 5;
  localparam int BJ_JAL  = 6;
  localparam int BJ_JALR = 7;

  localparam int EX_XLEN  = 64;
  localparam int EX_TAG_W = 5;

  // Default-width layout; the stage packs its flat payload in this field order.
  typedef struct packed {
    logic [EX_XLEN-1:0]  pc;
    logic [EX_XLEN-1:0]  result;
    logic [EX_XLEN-1:0]  store_data;
    logic [EX_TAG_W-1:0] rd;
    logic                wen;
    logic                exc;
  } ex_mem_t;

  function automatic int ex_mem_width(input int xlen, input int tag_w);
    return 3 * xlen + tag_w + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_commit_stage_skid_buf.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ex_commit_stage_skid_buf: 2-entry valid/ready register slice             |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module ex_commit_stage_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         push;
  logic         drain;

  assign in_ready = ~skid_valid;
  assign push     = in_valid & ~skid_valid;
  assign drain    = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      // Input is blocked while the skid entry is occupied; only refill main.
      if (drain) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (push && (!out_valid || drain)) begin
      out_data  <= in_data;
      out_valid <= 1'b1;
    end else if (push) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_commit_stage.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ex_commit_stage: branch resolve, fetch redirect and EX/MEM register      |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module ex_commit_stage
  import ex_commit_stage_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter bit RVC   = 1'b1,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_result,
  input  logic [XLEN-1:0]  in_base,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [7:0]       in_bj,
  input  logic [XLEN-1:0]  in_store_data,
  input  logic [TAG_W-1:0] in_rd,
  input  logic             in_wen,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_result,
  output logic [XLEN-1:0]  out_store_data,
  output logic [TAG_W-1:0] out_rd,
  output logic             out_wen,
  output logic             out_exc
);

  localparam int PW = ex_mem_width(XLEN, TAG_W);

  logic            accept;
  logic            keep;
  logic            taken;
  logic            misaligned;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] target;
  logic [PW-1:0]   pay_in;
  logic [PW-1:0]   pay_out;

  assign accept = in_valid & in_ready;
  // Anything accepted while a redirect is out is wrong-path: handshake, then drop.
  assign keep   = in_valid & ~redirect_valid;

  assign sum    = in_base + in_imm;
  assign target = in_bj[BJ_JALR] ? {sum[XLEN-1:1], 1'b0} : sum;

  assign taken = in_bj[BJ_JAL] | in_bj[BJ_JALR]
               | ((in_bj[BJ_BEQ] | in_bj[BJ_BLT] | in_bj[BJ_BLTU]) &  in_result[0])
               | ((in_bj[BJ_BNE] | in_bj[BJ_BGE] | in_bj[BJ_BGEU]) & ~in_result[0]);

  assign misaligned = (RVC == 1'b0) && taken && target[1];

  assign pay_in = {in_pc, in_result, in_store_data, in_rd, in_wen & ~misaligned, misaligned};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= accept & ~flush & ~redirect_valid & taken & ~misaligned;
      if (accept && taken) begin
        redirect_pc <= target;
      end
    end
  end

  ex_commit_stage_skid_buf #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (keep),
    .in_ready  (in_ready),
    .in_data   (pay_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_out)
  );

  assign {out_pc, out_result, out_store_data, out_rd, out_wen, out_exc} = pay_out;

endmodule
`default_nettype wire

// File: tb/tb_ex_commit_stage.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_ex_commit_stage: directed scoreboard bench for ex_commit_stage        |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module tb_ex_commit_stage;
  import ex_commit_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_wen = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] in_pc = '0, in_result = '0, in_base = '0, in_imm = '0, in_store_data = '0;
  logic [7:0]  in_bj = '0;
  logic [4:0]  in_rd = '0;

  logic        in_ready, redirect_valid, out_valid, out_wen, out_exc;
  logic [63:0] redirect_pc, out_pc, out_result, out_store_data;
  logic [4:0]  out_rd;

  logic        in_ready_1, redirect_valid_1, out_valid_1, out_wen_1, out_exc_1;
  logic [63:0] redirect_pc_1, out_pc_1, out_result_1, out_store_data_1;
  logic [4:0]  out_rd_1;

  always #5 clk = ~clk;

  ex_commit_stage #(.XLEN(64), .RVC(1'b1), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_result(in_result), .in_base(in_base), .in_imm(in_imm), .in_bj(in_bj),
    .in_store_data(in_store_data), .in_rd(in_rd), .in_wen(in_wen),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_result(out_result),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_wen(out_wen), .out_exc(out_exc)
  );

  ex_commit_stage #(.XLEN(64), .RVC(1'b0), .TAG_W(5)) dut_norvc (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_1),
    .in_pc(in_pc), .in_result(in_result), .in_base(in_base), .in_imm(in_imm), .in_bj(in_bj),
    .in_store_data(in_store_data), .in_rd(in_rd), .in_wen(in_wen),
    .redirect_valid(redirect_valid_1), .redirect_pc(redirect_pc_1),
    .out_valid(out_valid_1), .out_ready(out_ready), .out_pc(out_pc_1), .out_result(out_result_1),
    .out_store_data(out_store_data_1), .out_rd(out_rd_1), .out_wen(out_wen_1), .out_exc(out_exc_1)
  );

  ex_mem_t     oq[$];
  logic [63:0] rq[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: pops one expected entry per completed memory-side handshake.
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      if (oq.size() == 0) chk("unexpected_out", {1'b1, out_pc}, 0);
      else chk("out_entry", {out_pc, out_result, out_store_data, out_rd, out_wen, out_exc},
               oq.pop_front());
    end
    if (rst_n && redirect_valid) begin
      if (rq.size() == 0) chk("unexpected_redirect", {1'b1, redirect_pc}, 0);
      else chk("redirect_pc", redirect_pc, rq.pop_front());
    end
  end

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [63:0] pc, input logic [63:0] res, input logic [63:0] base,
                      input logic [63:0] imm, input logic [7:0] bj, input logic [4:0] rd,
                      input logic wen, input logic keep, input logic redir, input logic [63:0] rpc);
    ex_mem_t e;
    int n;
    in_pc = pc; in_result = res; in_base = base; in_imm = imm; in_bj = bj;
    in_rd = rd; in_wen = wen; in_store_data = ~pc; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    e.pc = pc; e.result = res; e.store_data = ~pc; e.rd = rd; e.wen = wen; e.exc = 1'b0;
    if (keep) oq.push_back(e);
    if (redir) rq.push_back(rpc);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("redirect_latency", redirect_valid, redir);
  endtask

  initial begin
    time t0;
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    rst_n = 1'b1;
    idle();

    // plain ALU op, then taken beq with wrong-path victim
    send(64'h100, 64'hDEAD, 64'h0, 64'h0, 8'h00, 5'd3, 1'b1, 1'b1, 1'b0, 64'h0);
    send(64'h1000, 64'h1, 64'h1000, 64'h40, 8'h01, 5'd0, 1'b0, 1'b1, 1'b1, 64'h1040);
    send(64'h1004, 64'h77, 64'h0, 64'h0, 8'h00, 5'd4, 1'b1, 1'b0, 1'b0, 64'h0);
    send(64'h1040, 64'h55, 64'h0, 64'h0, 8'h00, 5'd5, 1'b1, 1'b1, 1'b0, 64'h0);

    // jalr to 0x2003: legal with RVC, misaligned without
    send(64'h3000, 64'h3004, 64'h2003, 64'h0, 8'h80, 5'd1, 1'b1, 1'b1, 1'b1, 64'h2002);
    chk("norvc_out_valid", out_valid_1, 1);
    chk("norvc_out_pc", out_pc_1, 64'h3000);
    chk("norvc_out_exc", out_exc_1, 1);
    chk("norvc_out_wen", out_wen_1, 0);
    chk("norvc_no_redirect", redirect_valid_1, 0);
    idle();
    send(64'h3100, 64'h3104, 64'h2001, 64'h10, 8'h80, 5'd2, 1'b1, 1'b1, 1'b1, 64'h2010);
    idle();

    // bge not taken, wrapped target not taken, then taken wrap
    send(64'h4000, 64'h1, 64'h4000, 64'h8, 8'h08, 5'd6, 1'b0, 1'b1, 1'b0, 64'h0);
    send(64'h4004, 64'h1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 8'h08, 5'd6, 1'b0, 1'b1, 1'b0, 64'h0);
    send(64'h4008, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 8'h08, 5'd6, 1'b0, 1'b1, 1'b1,
         64'hFFFF_FFFF_FFFF_FFFC);
    idle();
    send(64'h5000, 64'h0, 64'h500, 64'h20, 8'h02, 5'd7, 1'b0, 1'b1, 1'b1, 64'h520);
    idle();
    send(64'h5004, 64'h0, 64'h500, 64'h20, 8'h10, 5'd7, 1'b0, 1'b1, 1'b0, 64'h0);
    send(64'h6000, 64'h6004, 64'h600, 64'hFFFF_FFFF_FFFF_FF00, 8'h40, 5'd1, 1'b1, 1'b1, 1'b1,
         64'h500);
    idle();

    // backpressure: A,B fill both entries, C,D wait
    out_ready = 1'b0;
    fork
      begin
        send(64'hA0, 64'hA, 64'h0, 64'h0, 8'h00, 5'd10, 1'b1, 1'b1, 1'b0, 64'h0);
        send(64'hB0, 64'hB, 64'h0, 64'h0, 8'h00, 5'd11, 1'b1, 1'b1, 1'b0, 64'h0);
        send(64'hC0, 64'hC, 64'h0, 64'h0, 8'h00, 5'd12, 1'b1, 1'b1, 1'b0, 64'h0);
        send(64'hD0, 64'hD, 64'h0, 64'h0, 8'h00, 5'd13, 1'b1, 1'b1, 1'b0, 64'h0);
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_hold_pc", out_pc, 64'hA0);
        out_ready = 1'b1;
      end
    join
    repeat (3) idle();

    // sustained one-per-cycle throughput
    t0 = $time;
    send(64'h7000, 64'h1, 64'h0, 64'h0, 8'h00, 5'd1, 1'b1, 1'b1, 1'b0, 64'h0);
    send(64'h7004, 64'h2, 64'h0, 64'h0, 8'h00, 5'd2, 1'b1, 1'b1, 1'b0, 64'h0);
    send(64'h7008, 64'h3, 64'h0, 64'h0, 8'h00, 5'd3, 1'b1, 1'b1, 1'b0, 64'h0);
    send(64'h700C, 64'h4, 64'h0, 64'h0, 8'h00, 5'd4, 1'b1, 1'b1, 1'b0, 64'h0);
    chk("throughput_time", $time - t0, 40);
    repeat (2) idle();

    // flush with full skid and a taken jal presented
    out_ready = 1'b0;
    send(64'hE0, 64'hE, 64'h0, 64'h0, 8'h00, 5'd14, 1'b1, 1'b1, 1'b0, 64'h0);
    send(64'hF0, 64'hF, 64'h0, 64'h0, 8'h00, 5'd15, 1'b1, 1'b1, 1'b0, 64'h0);
    in_bj = 8'h40; in_base = 64'h700; in_imm = 64'h10; in_valid = 1'b1; flush = 1'b1;
    idle();
    flush = 1'b0; in_valid = 1'b0;
    oq.delete(); rq.delete();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_redirect", redirect_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;

    // flush while a taken jal is actually accepted
    in_valid = 1'b1; flush = 1'b1;
    idle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_acc_out_valid", out_valid, 0);
    chk("flush_acc_redirect", redirect_valid, 0);
    repeat (2) idle();

    // async reset with a redirect pending and input valid
    out_ready = 1'b0;
    send(64'h800, 64'h804, 64'h800, 64'h100, 8'h40, 5'd1, 1'b1, 1'b1, 1'b1, 64'h900);
    in_valid = 1'b1; rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_redirect", redirect_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    oq.delete(); rq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    send(64'h900, 64'h9, 64'h0, 64'h0, 8'h00, 5'd9, 1'b1, 1'b1, 1'b0, 64'h0);

    n = 0;
    while ((oq.size() != 0 || rq.size() != 0) && n < 20) begin
      idle();
      n++;
    end
    chk("queues_drained", oq.size() + rq.size(), 0);
    repeat (2) idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
